// File: rtl/alarm_pkg.sv
// ---------------------------------------------------------------------------
// alarm_pkg
// Shared types and constants for the alarm controller keypad front end.
//   digit_t       : one keypad code / PIN digit (4 bits)
//   code_state_t  : PIN entry FSM states (LOCKOUT only reachable when the
//                   CODE_LOCKOUT_EN macro is defined)
//   KEY_IDLE      : keypad bus value while no key is pressed
//   KEY_CLEAR     : keypad bus value of the CLEAR key
//   is_digit      : key is one of 0..9
//   is_event_key  : key produces a press event (digits and CLEAR); codes
//                   B..E are debounced like any key but never reported
// ---------------------------------------------------------------------------
package alarm_pkg;

   typedef logic [3:0] digit_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_CHECK   = 2'd2,
      ST_LOCKOUT = 2'd3
   } code_state_t;

   localparam digit_t KEY_IDLE       = 4'hF;
   localparam digit_t KEY_CLEAR      = 4'hA;
   localparam digit_t KEY_LAST_DIGIT = 4'h9;

   function automatic logic is_digit(input digit_t k);
      return (k <= KEY_LAST_DIGIT);
   endfunction

   function automatic logic is_event_key(input digit_t k);
      return (k <= KEY_CLEAR);
   endfunction

endpackage

// File: rtl/key_debouncer.sv
// ---------------------------------------------------------------------------
// key_debouncer
// Turns the synchronized keypad bus into single press events. The bus is
// sampled only on ENA ticks; a value must be seen on DEBOUNCE_TICKS
// consecutive samples to count as stable. A stable non-idle value yields one
// press (if it is a digit or CLEAR), after which the idle code must itself
// become stable before another press is accepted, so a held key never
// repeats.
// Ports:
//   clk     in   system clock
//   reset   in   synchronous active-high reset; leaves the block waiting for
//                a stable idle level so a key held through reset is ignored
//   ENA     in   sample strobe (one clk wide)
//   keypad  in   4-bit keypad code, already synchronized
//   press   out  one-cycle pulse, registered on the completing ENA edge
//   key     out  key value that caused the press (valid with press)
// ---------------------------------------------------------------------------
module key_debouncer
   import alarm_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ENA,
   input  logic [3:0] keypad,
   output logic       press,
   output logic [3:0] key
);

   localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [CW-1:0] CNT_STABLE = CW'(DEBOUNCE_TICKS);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

   digit_t          last_reg;
   logic [CW-1:0]   run_cnt_reg;
   logic [CW-1:0]   run_cnt_next;
   logic            armed_reg;
   logic            press_reg;
   digit_t          key_reg;
   logic            stable;

   // Run length of the current sample value, saturating at the stable
   // threshold. A different value restarts the run at one.
   always_comb begin
      run_cnt_next = run_cnt_reg;
      if (keypad != last_reg) begin
         run_cnt_next = CNT_ONE;
      end else if (run_cnt_reg != CNT_STABLE) begin
         run_cnt_next = run_cnt_reg + 1'b1;
      end
   end

   assign stable = (run_cnt_next == CNT_STABLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         last_reg    <= KEY_IDLE;
         run_cnt_reg <= '0;
         armed_reg   <= 1'b0;
         press_reg   <= 1'b0;
         key_reg     <= '0;
      end else begin
         press_reg <= 1'b0;
         if (ENA) begin
            last_reg    <= keypad;
            run_cnt_reg <= run_cnt_next;
            if (armed_reg && stable && (keypad != KEY_IDLE)) begin
               // Any stable key consumes the arm, but only digits and
               // CLEAR are reported downstream.
               armed_reg <= 1'b0;
               press_reg <= is_event_key(keypad);
               key_reg   <= keypad;
            end else if (!armed_reg && stable && (keypad == KEY_IDLE)) begin
               armed_reg <= 1'b1;
            end
         end
      end
   end

   assign press = press_reg;
   assign key   = key_reg;

endmodule

// File: rtl/keypad_code_entry.sv
// ---------------------------------------------------------------------------
// keypad_code_entry
// Collects debounced digits into a CODE_LEN-digit PIN and emits a one-cycle
// verdict pulse (code_ok / code_bad) to the alarm FSM. A partial entry is
// dropped after TIMEOUT_TICKS ENA ticks without a press, or by CLEAR.
// Optional feature macro: CODE_LOCKOUT_EN. When defined, MAX_FAILS
// consecutive bad codes lock the keypad for LOCKOUT_TICKS ENA ticks.
// Ports:
//   clk         in   system clock
//   reset       in   synchronous active-high reset
//   ENA         in   divider tick, timebase for debounce/timeout/lockout
//   keypad      in   4-bit keypad code, already synchronized
//   code_ok     out  one-cycle pulse, entered PIN equals SECRET
//   code_bad    out  one-cycle pulse, full-length PIN mismatched
//   entry_busy  out  high while digits are being collected
//   digit_cnt   out  digits collected so far
//   locked_out  out  lockout active (constant 0 without CODE_LOCKOUT_EN)
// Timing: press event on ENA edge t, digit stored at t+1; for the last digit
// CHECK is entered at t+1 and the verdict pulse is registered at t+2.
// ---------------------------------------------------------------------------
module keypad_code_entry
   import alarm_pkg::*;
#(
   parameter int          CODE_LEN       = 4,
   parameter logic [23:0] SECRET         = 24'h00_1234,
   parameter int          DEBOUNCE_TICKS = 3,
   parameter int          TIMEOUT_TICKS  = 100,
   parameter int          MAX_FAILS      = 3,
   parameter int          LOCKOUT_TICKS  = 200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ENA,
   input  logic [3:0] keypad,
   output logic       code_ok,
   output logic       code_bad,
   output logic       entry_busy,
   output logic [2:0] digit_cnt,
   output logic       locked_out
);

   localparam int EW = 4 * CODE_LEN;
   localparam int TW = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_TICKS - 1);
   localparam logic [2:0]    DIGIT_LAST   = 3'(CODE_LEN - 1);

   // Out-of-range configurations are rejected at elaboration.
   if (CODE_LEN < 1 || CODE_LEN > 6 || DEBOUNCE_TICKS < 1 ||
       TIMEOUT_TICKS < 1 || MAX_FAILS < 1 || LOCKOUT_TICKS < 1) begin : g_bad_config
      $error("keypad_code_entry: parameter out of range");
   end

   // ------------------------------------------------------------------
   // Debounced key events
   // ------------------------------------------------------------------
   logic   press;
   digit_t key;

   key_debouncer #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
   ) u_debouncer (
      .clk    (clk),
      .reset  (reset),
      .ENA    (ENA),
      .keypad (keypad),
      .press  (press),
      .key    (key)
   );

   logic press_digit;
   logic press_clear;

   assign press_digit = press && is_digit(key);
   assign press_clear = press && (key == KEY_CLEAR);

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   code_state_t   state_reg,     state_next;
   logic [EW-1:0] entry_reg,     entry_next;
   logic [2:0]    digit_cnt_reg, digit_cnt_next;
   logic [TW-1:0] timeout_reg,   timeout_next;
   logic          code_ok_reg,   code_ok_next;
   logic          code_bad_reg,  code_bad_next;

`ifdef CODE_LOCKOUT_EN
   localparam int FW = $clog2(MAX_FAILS + 1);
   localparam int LW = $clog2(LOCKOUT_TICKS + 1);
   localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAILS - 1);
   localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_TICKS - 1);

   logic [FW-1:0] fail_reg, fail_next;
   logic [LW-1:0] lock_reg, lock_next;
`endif

   // ------------------------------------------------------------------
   // Entry shift register: newest digit enters the low nibble, so the
   // first digit ends up in the most significant nibble like SECRET.
   // ------------------------------------------------------------------
   logic [EW-1:0] entry_shift;

   if (CODE_LEN == 1) begin : g_shift_single
      assign entry_shift = key;
   end else begin : g_shift_multi
      assign entry_shift = {entry_reg[EW-5:0], key};
   end

   // Per-digit comparison against the secret.
   logic [CODE_LEN-1:0] nibble_match;
   logic                code_match;

   for (genvar gi = 0; gi < CODE_LEN; gi++) begin : g_match
      assign nibble_match[gi] = (entry_reg[4*gi +: 4] == SECRET[4*gi +: 4]);
   end

   assign code_match = &nibble_match;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      entry_next     = entry_reg;
      digit_cnt_next = digit_cnt_reg;
      timeout_next   = timeout_reg;
      code_ok_next   = 1'b0;
      code_bad_next  = 1'b0;
`ifdef CODE_LOCKOUT_EN
      fail_next      = fail_reg;
      lock_next      = lock_reg;
`endif

      case (state_reg)
         ST_IDLE: begin
            if (press_digit) begin
               entry_next     = entry_shift;
               digit_cnt_next = 3'd1;
               timeout_next   = '0;
               state_next     = (CODE_LEN == 1) ? ST_CHECK : ST_COLLECT;
            end
         end

         ST_COLLECT: begin
            // A press on the same cycle as the timeout expiry takes
            // priority: the digit is kept and the timer restarts.
            if (press_digit) begin
               entry_next     = entry_shift;
               digit_cnt_next = digit_cnt_reg + 3'd1;
               timeout_next   = '0;
               if (digit_cnt_reg == DIGIT_LAST) begin
                  state_next = ST_CHECK;
               end
            end else if (press_clear) begin
               entry_next     = '0;
               digit_cnt_next = '0;
               timeout_next   = '0;
               state_next     = ST_IDLE;
            end else if (ENA) begin
               if (timeout_reg == TIMEOUT_LAST) begin
                  entry_next     = '0;
                  digit_cnt_next = '0;
                  timeout_next   = '0;
                  state_next     = ST_IDLE;
               end else begin
                  timeout_next = timeout_reg + 1'b1;
               end
            end
         end

         ST_CHECK: begin
            code_ok_next   = code_match;
            code_bad_next  = !code_match;
            entry_next     = '0;
            digit_cnt_next = '0;
            timeout_next   = '0;
            state_next     = ST_IDLE;
`ifdef CODE_LOCKOUT_EN
            if (code_match) begin
               fail_next = '0;
            end else begin
               fail_next = fail_reg + 1'b1;
               if (fail_reg == FAIL_LAST) begin
                  lock_next  = '0;
                  state_next = ST_LOCKOUT;
               end
            end
`endif
         end

         ST_LOCKOUT: begin
`ifdef CODE_LOCKOUT_EN
            // Presses are simply dropped here; only ENA ticks matter.
            if (ENA) begin
               if (lock_reg == LOCK_LAST) begin
                  lock_next  = '0;
                  fail_next  = '0;
                  state_next = ST_IDLE;
               end else begin
                  lock_next = lock_reg + 1'b1;
               end
            end
`else
            state_next = ST_IDLE;
`endif
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State and data registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         entry_reg     <= '0;
         digit_cnt_reg <= '0;
         timeout_reg   <= '0;
         code_ok_reg   <= 1'b0;
         code_bad_reg  <= 1'b0;
`ifdef CODE_LOCKOUT_EN
         fail_reg      <= '0;
         lock_reg      <= '0;
`endif
      end else begin
         state_reg     <= state_next;
         entry_reg     <= entry_next;
         digit_cnt_reg <= digit_cnt_next;
         timeout_reg   <= timeout_next;
         code_ok_reg   <= code_ok_next;
         code_bad_reg  <= code_bad_next;
`ifdef CODE_LOCKOUT_EN
         fail_reg      <= fail_next;
         lock_reg      <= lock_next;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign code_ok    = code_ok_reg;
   assign code_bad   = code_bad_reg;
   assign entry_busy = (state_reg == ST_COLLECT);
   assign digit_cnt  = digit_cnt_reg;

`ifdef CODE_LOCKOUT_EN
   assign locked_out = (state_reg == ST_LOCKOUT);
`else
   assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_code_entry.sv
// ---------------------------------------------------------------------------
// tb_keypad_code_entry
// Directed stimulus for keypad_code_entry. ENA is one clk in four; each
// "tick" below is one ENA period. A reference model built from the entry
// rules (digit queue, run-length debounce, tick counters) predicts every
// output each cycle, and literal checks pin the key scenarios.
// ---------------------------------------------------------------------------
module tb_keypad_code_entry;

   localparam int          CODE_LEN       = 4;
   localparam logic [23:0] SECRET         = 24'h00_1234;
   localparam int          DEBOUNCE_TICKS = 3;
   localparam int          TIMEOUT_TICKS  = 100;
   localparam int          MAX_FAILS      = 3;
   localparam int          LOCKOUT_TICKS  = 200;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ENA = 1'b0;
   logic [3:0] keypad = 4'h1;
   logic       code_ok;
   logic       code_bad;
   logic       entry_busy;
   logic [2:0] digit_cnt;
   logic       locked_out;

   always #5 clk = ~clk;

   keypad_code_entry #(
      .CODE_LEN       (CODE_LEN),
      .SECRET         (SECRET),
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .TIMEOUT_TICKS  (TIMEOUT_TICKS),
      .MAX_FAILS      (MAX_FAILS),
      .LOCKOUT_TICKS  (LOCKOUT_TICKS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ENA        (ENA),
      .keypad     (keypad),
      .code_ok    (code_ok),
      .code_bad   (code_bad),
      .entry_busy (entry_busy),
      .digit_cnt  (digit_cnt),
      .locked_out (locked_out)
   );

   int total = 0;
   int bad   = 0;
   int ok_seen  = 0;
   int bad_seen = 0;

   // ---------------- reference model state ----------------
   int         m_pin[$];
   bit         m_checking = 1'b0;
   int         m_lock  = 0;
   int         m_fails = 0;
   int         m_idle  = 0;
   logic [3:0] m_run_val = 4'hF;
   int         m_run_len = 0;
   bit         m_wait_idle = 1'b1;
   bit         m_ev = 1'b0;
   logic [3:0] m_ev_key = 4'h0;
   bit         e_ok = 1'b0;
   bit         e_bad = 1'b0;
   bit         e_busy = 1'b0;
   bit         e_locked = 1'b0;
   int         e_cnt = 0;

   task automatic check(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
      end
   endtask

   function automatic int secret_digit(input int i);
      logic [23:0] s;
      s = SECRET >> (4 * (CODE_LEN - 1 - i));
      return int'(s[3:0]);
   endfunction

   // One clock edge of the model, applied with the inputs the DUT sees.
   task automatic model_step();
      bit         ev_use;
      logic [3:0] ev_key_use;
      bit         match;
      ev_use     = m_ev;
      ev_key_use = m_ev_key;
      m_ev  = 1'b0;
      e_ok  = 1'b0;
      e_bad = 1'b0;
      if (reset) begin
         m_pin.delete();
         m_checking  = 1'b0;
         m_lock      = 0;
         m_fails     = 0;
         m_idle      = 0;
         m_run_val   = 4'hF;
         m_run_len   = 0;
         m_wait_idle = 1'b1;
      end else begin
         if (m_checking) begin
            match = 1'b1;
            for (int i = 0; i < CODE_LEN; i++)
               if (m_pin[i] != secret_digit(i)) match = 1'b0;
            e_ok  = match;
            e_bad = !match;
            m_pin.delete();
            m_checking = 1'b0;
`ifdef CODE_LOCKOUT_EN
            if (match) m_fails = 0;
            else begin
               m_fails++;
               if (m_fails == MAX_FAILS) m_lock = LOCKOUT_TICKS;
            end
`endif
         end else if (m_lock > 0) begin
            if (ENA) begin
               m_lock--;
               if (m_lock == 0) m_fails = 0;
            end
         end else if (ev_use && ev_key_use <= 4'h9) begin
            m_pin.push_back(int'(ev_key_use));
            m_idle = 0;
            if (m_pin.size() == CODE_LEN) m_checking = 1'b1;
         end else if (ev_use && ev_key_use == 4'hA) begin
            m_pin.delete();
         end else if (m_pin.size() > 0 && ENA) begin
            m_idle++;
            if (m_idle == TIMEOUT_TICKS) m_pin.delete();
         end

         if (ENA) begin
            if (keypad == m_run_val) m_run_len++;
            else begin
               m_run_val = keypad;
               m_run_len = 1;
            end
            if (m_run_len == DEBOUNCE_TICKS) begin
               if (m_run_val == 4'hF) m_wait_idle = 1'b0;
               else if (!m_wait_idle) begin
                  m_wait_idle = 1'b1;
                  if (m_run_val <= 4'hA) begin
                     m_ev     = 1'b1;
                     m_ev_key = m_run_val;
                  end
               end
            end
         end
      end
      e_busy   = (m_pin.size() > 0) && !m_checking;
      e_cnt    = m_pin.size();
      e_locked = (m_lock > 0);
   endtask

   // One ENA period holding keypad at k: three quiet clocks, then ENA.
   task automatic ena_tick(input logic [3:0] k);
      keypad = k;
      ENA = 1'b0;
      repeat (3) @(negedge clk);
      ENA = 1'b1;
      @(negedge clk);
      ENA = 1'b0;
   endtask

   task automatic press_key(input logic [3:0] k, input int hold, input int gap);
      $display("key %h hold=%0d gap=%0d cnt=%0d", k, hold, gap, digit_cnt);
      repeat (hold) ena_tick(k);
      repeat (gap) ena_tick(4'hF);
   endtask

   task automatic enter4(input logic [15:0] code);
      for (int i = 3; i >= 0; i--) press_key(code[4*i +: 4], 5, 5);
   endtask

   int ok0;
   int bad0;

   initial begin
      fork
         forever begin
            @(posedge clk);
            model_step();
         end
         forever begin
            @(negedge clk);
            check("code_ok",    int'(code_ok),    int'(e_ok));
            check("code_bad",   int'(code_bad),   int'(e_bad));
            check("entry_busy", int'(entry_busy), int'(e_busy));
            check("digit_cnt",  int'(digit_cnt),  e_cnt);
            check("locked_out", int'(locked_out), int'(e_locked));
            if (code_ok)  ok_seen++;
            if (code_bad) bad_seen++;
         end
      join_none

      // Reset with key 1 already held; it must not register afterwards.
      repeat (2) @(negedge clk);
      ENA = 1'b1;
      @(negedge clk);
      ENA = 1'b0;
      check("reset_cnt",  int'(digit_cnt),  0);
      check("reset_busy", int'(entry_busy), 0);
      check("reset_ok",   int'(code_ok),    0);
      reset = 1'b0;
      press_key(4'h1, 6, 5);
      check("held_thru_reset_cnt", int'(digit_cnt), 0);

      // 1,2,3,4 with the verdict timing pinned on the last digit.
      ok0 = ok_seen; bad0 = bad_seen;
      press_key(4'h1, 5, 5);
      press_key(4'h2, 5, 5);
      press_key(4'h3, 5, 5);
      $display("key 4 hold=5 gap=5 cnt=%0d", digit_cnt);
      repeat (3) ena_tick(4'h4);
      @(negedge clk);
      check("s1_cnt_t1",  int'(digit_cnt),  4);
      check("s1_busy_t1", int'(entry_busy), 0);
      check("s1_ok_t1",   int'(code_ok),    0);
      @(negedge clk);
      check("s1_ok_t2",   int'(code_ok),    1);
      check("s1_cnt_t2",  int'(digit_cnt),  0);
      repeat (2) ena_tick(4'h4);
      repeat (5) ena_tick(4'hF);
      check("s1_ok_pulses",  ok_seen - ok0,   1);
      check("s1_bad_pulses", bad_seen - bad0, 0);

      // 1,2,3,5 -> mismatch.
      ok0 = ok_seen; bad0 = bad_seen;
      enter4(16'h1235);
      check("s2_ok_pulses",  ok_seen - ok0,   0);
      check("s2_bad_pulses", bad_seen - bad0, 1);
      check("s2_cnt",        int'(digit_cnt), 0);

      // Short hold rejected, long hold gives exactly one digit.
      press_key(4'h7, 2, 5);
      check("s3_short_cnt", int'(digit_cnt), 0);
      press_key(4'h7, 50, 5);
      check("s3_long_cnt",  int'(digit_cnt),  1);
      check("s3_long_busy", int'(entry_busy), 1);
      press_key(4'hA, 5, 5);
      check("s3_clear_cnt",  int'(digit_cnt),  0);
      check("s3_clear_busy", int'(entry_busy), 0);

      // 1,2,CLEAR,1,2,3,4 -> single ok.
      ok0 = ok_seen; bad0 = bad_seen;
      press_key(4'h1, 5, 5);
      press_key(4'h2, 5, 5);
      press_key(4'hA, 5, 5);
      enter4(16'h1234);
      check("s4_ok_pulses",  ok_seen - ok0,   1);
      check("s4_bad_pulses", bad_seen - bad0, 0);

      // Ignored key C.
      press_key(4'hC, 5, 5);
      check("s5_ignored_cnt",  int'(digit_cnt),  0);
      check("s5_ignored_busy", int'(entry_busy), 0);

      // Key 9 then timeout after 100 ENA ticks without a press.
      ok0 = ok_seen; bad0 = bad_seen;
      press_key(4'h9, 5, 5);
      repeat (92) ena_tick(4'hF);
      check("s6_busy_tick99",  int'(entry_busy), 1);
      ena_tick(4'hF);
      check("s6_busy_tick100", int'(entry_busy), 0);
      check("s6_cnt_tick100",  int'(digit_cnt),  0);
      check("s6_no_pulses",    (ok_seen - ok0) + (bad_seen - bad0), 0);
      enter4(16'h1234);
      check("s6_ok_after", ok_seen - ok0, 1);

`ifdef CODE_LOCKOUT_EN
      // Three bad codes -> lockout; correct code during lockout ignored.
      ok0 = ok_seen; bad0 = bad_seen;
      enter4(16'h1235);
      enter4(16'h1235);
      enter4(16'h1235);
      check("lk_bad_pulses", bad_seen - bad0, 3);
      check("lk_active",     int'(locked_out), 1);
      enter4(16'h1234);
      check("lk_ok_ignored", ok_seen - ok0, 0);
      check("lk_still",      int'(locked_out), 1);
      repeat (160) ena_tick(4'hF);
      check("lk_released",   int'(locked_out), 0);
      enter4(16'h1234);
      check("lk_ok_after",   ok_seen - ok0, 1);
      enter4(16'h1235);
      enter4(16'h1235);
      enter4(16'h1235);
      check("lk_again", int'(locked_out), 1);
      reset = 1'b1;
      @(negedge clk);
      check("lk_reset_release", int'(locked_out), 0);
      reset = 1'b0;
      repeat (5) ena_tick(4'hF);
      enter4(16'h1234);
      check("lk_ok_post_reset", ok_seen - ok0, 2);
`endif

      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
